// File: rtl/pwm_multi.sv
// Multi-channel PWM with double-buffered period/duty applied at period boundaries.
// Optional macro PWM_CENTER_ALIGN_EN selects up/down (centre-aligned) counting.
module pwm_multi #(
    parameter int CH = 4,
    parameter int CW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [CW-1:0]      period,
    input  logic [CH*CW-1:0]   duty,
    input  logic               load,
    output logic [CH-1:0]      pwm_out,
    output logic [CW-1:0]      cnt,
    output logic               period_start,
    output logic               upd_pending
);

    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          p_act_q, p_act_d, p_pen_q, p_pen_d;
    logic [CH-1:0][CW-1:0]  d_act_q, d_act_d, d_pen_q, d_pen_d;
    logic                   upd_pending_q, upd_pending_d;
    logic [CH-1:0]          pwm_q, pwm_d;
    logic                   boundary_s;
    logic                   apply_s;
`ifdef PWM_CENTER_ALIGN_EN
    logic                   dir_dn_q, dir_dn_d;
`endif

    // Counter next state: sawtooth by default, triangle when centre-aligned
    always_comb begin
        cnt_d = cnt_q;
`ifdef PWM_CENTER_ALIGN_EN
        dir_dn_d = dir_dn_q;
        if (!en || (p_act_q == ZERO)) begin
            cnt_d    = ZERO;
            dir_dn_d = 1'b0;
        end else if (dir_dn_q) begin
            // Reaching 0 turns the count back up; that step is the boundary.
            if (cnt_q <= ONE) begin
                cnt_d    = ZERO;
                dir_dn_d = 1'b0;
            end else begin
                cnt_d    = cnt_q - ONE;
                dir_dn_d = 1'b1;
            end
        end else begin
            if (cnt_q >= p_act_q) begin
                cnt_d    = ZERO;
                dir_dn_d = 1'b0;
            end else begin
                cnt_d    = cnt_q + ONE;
                dir_dn_d = ((cnt_q + ONE) == p_act_q);
            end
        end
`else
        if (!en) begin
            cnt_d = ZERO;
        end else if (cnt_q >= p_act_q) begin
            cnt_d = ZERO;
        end else begin
            cnt_d = cnt_q + ONE;
        end
`endif
    end

    assign boundary_s = en && (cnt_d == ZERO);
    assign apply_s    = upd_pending_q && (boundary_s || !en);

    // Active/pending register updates; a coincident load re-arms the pending set
    always_comb begin
        p_act_d       = p_act_q;
        d_act_d       = d_act_q;
        p_pen_d       = p_pen_q;
        d_pen_d       = d_pen_q;
        upd_pending_d = upd_pending_q;
        if (apply_s) begin
            p_act_d       = p_pen_q;
            d_act_d       = d_pen_q;
            upd_pending_d = 1'b0;
        end else begin
            upd_pending_d = upd_pending_q;
        end
        if (load) begin
            p_pen_d       = period;
            d_pen_d       = duty;
            upd_pending_d = 1'b1;
        end else begin
            p_pen_d = p_pen_q;
        end
    end

    // PWM compare against the current counter, registered one clock later
    always_comb begin
        pwm_d = {CH{1'b0}};
        for (int i = 0; i < CH; i++) begin
            if (!en) begin
                pwm_d[i] = 1'b0;
            end else begin
`ifdef PWM_CENTER_ALIGN_EN
                // Down-leg includes the equal value so the pulse is 2*D wide.
                pwm_d[i] = dir_dn_q ? (cnt_q <= d_act_q[i]) : (cnt_q < d_act_q[i]);
`else
                pwm_d[i] = (cnt_q < d_act_q[i]);
`endif
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= ZERO;
            p_act_q       <= {CW{1'b1}};
            p_pen_q       <= {CW{1'b1}};
            d_act_q       <= {(CH*CW){1'b0}};
            d_pen_q       <= {(CH*CW){1'b0}};
            upd_pending_q <= 1'b0;
            pwm_q         <= {CH{1'b0}};
`ifdef PWM_CENTER_ALIGN_EN
            dir_dn_q      <= 1'b0;
`endif
        end else begin
            cnt_q         <= cnt_d;
            p_act_q       <= p_act_d;
            p_pen_q       <= p_pen_d;
            d_act_q       <= d_act_d;
            d_pen_q       <= d_pen_d;
            upd_pending_q <= upd_pending_d;
            pwm_q         <= pwm_d;
`ifdef PWM_CENTER_ALIGN_EN
            dir_dn_q      <= dir_dn_d;
`endif
        end
    end

    assign pwm_out      = pwm_q;
    assign cnt          = cnt_q;
    assign upd_pending  = upd_pending_q;
    assign period_start = en && (cnt_q == ZERO);

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi (sawtooth build, CH=4, CW=8) with an expectation queue.
module tb_pwm_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  period;
    logic [31:0] duty;
    logic        load;
    logic [3:0]  pwm_out;
    logic [7:0]  cnt;
    logic        period_start;
    logic        upd_pending;

    pwm_multi #(.CH(4), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .period(period), .duty(duty),
        .load(load), .pwm_out(pwm_out), .cnt(cnt),
        .period_start(period_start), .upd_pending(upd_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   hi[4];
    int   ps_cnt;
    int   max_cnt;

    task automatic push(input string tag, input int v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input int obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty observed=%0d", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_err++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic wait_cnt(input int target);
        int n;
        n = 0;
        while ((int'(cnt) != target) && (n < 400)) begin
            @(negedge clk);
            n++;
        end
        if (int'(cnt) != target) timeout($sformatf("wait_cnt_%0d", target));
    endtask

    task automatic measure(input int n);
        for (int c = 0; c < 4; c++) hi[c] = 0;
        ps_cnt  = 0;
        max_cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) if (pwm_out[c]) hi[c]++;
            if (period_start) ps_cnt++;
            if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
        end
    endtask

    task automatic do_load(input logic [7:0] p, input logic [31:0] d);
        period = p;
        duty   = d;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    initial begin : stim
        int n;
        int hi_rest;
        int upd99;
        rst_n  = 1'b0;
        en     = 1'b0;
        load   = 1'b0;
        period = 8'd0;
        duty   = 32'd0;

        // reset state
        @(negedge clk);
        push("rst_cnt", 0);   chk(int'(cnt));
        push("rst_pwm", 0);   chk(int'(pwm_out));
        push("rst_upd", 0);   chk(int'(upd_pending));
        push("rst_ps", 0);    chk(int'(period_start));
        rst_n = 1'b1;
        @(negedge clk);

        // load while disabled: pending, then applied on the next edge
        push("load_upd_set", 1);
        do_load(8'd99, {8'd80, 8'd60, 8'd40, 8'd20});
        chk(int'(upd_pending));
        push("dis_apply_upd", 0);
        @(negedge clk);
        chk(int'(upd_pending));

        // basic run: P=99, duties 20/40/60/80
        en = 1'b1;
        #1;
        push("en_rise_ps", 1);   chk(int'(period_start));
        push("base_hi0", 20); push("base_hi1", 40); push("base_hi2", 60); push("base_hi3", 80);
        push("base_ps", 1); push("base_cnt_max", 99); push("base_cnt_end", 0);
        measure(100);
        chk(hi[0]); chk(hi[1]); chk(hi[2]); chk(hi[3]);
        chk(ps_cnt); chk(max_cnt); chk(int'(cnt));
        push("per2_ps", 1); push("per2_hi3", 80);
        measure(100);
        chk(ps_cnt); chk(hi[3]);

        // mid-period load at cnt=30 waits for the wrap
        wait_cnt(30);
        push("mid_upd", 1);
        do_load(8'd99, {8'd80, 8'd60, 8'd40, 8'd50});
        chk(int'(upd_pending));
        push("mid_rest_hi0", 0); push("mid_upd_at99", 1); push("mid_upd_wrap", 0);
        hi_rest = 0;
        upd99   = -1;
        n       = 0;
        while ((cnt != 8'd0) && (n < 200)) begin
            @(negedge clk);
            n++;
            if (pwm_out[0]) hi_rest++;
            if (cnt == 8'd99) upd99 = int'(upd_pending);
        end
        chk(hi_rest); chk(upd99); chk(int'(upd_pending));
        push("mid_new_hi0", 50); push("mid_new_hi1", 40);
        measure(100);
        chk(hi[0]); chk(hi[1]);

        // duty 0 and duty above period
        do_load(8'd99, {8'd80, 8'd60, 8'd120, 8'd0});
        n = 0;
        while (upd_pending && (n < 300)) begin
            @(negedge clk);
            n++;
        end
        if (upd_pending) timeout("wait_upd_clear");
        push("edge_cnt_at_apply", 0); chk(int'(cnt));
        push("edge_hi0", 0); push("edge_hi1", 100);
        measure(100);
        chk(hi[0]); chk(hi[1]);

        // load on the boundary cycle while an update is pending
        wait_cnt(50);
        do_load(8'd99, {8'd80, 8'd60, 8'd120, 8'd10});
        wait_cnt(99);
        do_load(8'd99, {8'd80, 8'd60, 8'd120, 8'd70});
        push("coin_upd", 1); push("coin_cnt", 0);
        chk(int'(upd_pending)); chk(int'(cnt));
        push("coin_hiA", 10); push("coin_upd_after", 0);
        measure(100);
        chk(hi[0]); chk(int'(upd_pending));
        push("coin_hiB", 70);
        measure(100);
        chk(hi[0]);

        // en falls mid-period
        wait_cnt(40);
        en = 1'b0;
        @(negedge clk);
        push("dis_pwm", 0); push("dis_cnt", 0); push("dis_ps", 0);
        chk(int'(pwm_out)); chk(int'(cnt)); chk(int'(period_start));

        // async reset at cnt=57 discards a pending load
        en = 1'b1;
        wait_cnt(50);
        do_load(8'd20, {8'd5, 8'd5, 8'd5, 8'd5});
        wait_cnt(57);
        push("ar_pre_pwm1", 1); chk(int'(pwm_out[1]));
        rst_n = 1'b0;
        #1;
        push("ar_cnt", 0); push("ar_pwm", 0); push("ar_upd", 0);
        chk(int'(cnt)); chk(int'(pwm_out)); chk(int'(upd_pending));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        push("ar_rel_ps", 1); chk(int'(period_start));
        push("ar_period", 256); push("ar_max", 255); push("ar_hi", 0);
        n       = 0;
        max_cnt = 0;
        hi_rest = 0;
        do begin
            @(negedge clk);
            n++;
            if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
            if (pwm_out != 4'd0) hi_rest++;
        end while ((cnt != 8'd0) && (n < 400));
        chk(n); chk(max_cnt); chk(hi_rest);

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 SHALL have parameter CH, default 4, meaning number of PWM channels (1..16).
REQ-002 SHALL have parameter CW, default 8, meaning counter, period and duty width in bits (2..16).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port en  input  1  meaning counter run enable.
REQ-006 SHALL have port period  input  CW  meaning requested terminal count P; period length is P+1 clocks.
REQ-007 SHALL have port duty  input  CH*CW  meaning requested duty for each channel; channel i occupies bits [i*CW +: CW].
REQ-008 SHALL have port load  input  1  meaning one-cycle strobe that captures period and duty into pending registers.
REQ-009 SHALL have port pwm_out  output  CH  meaning registered PWM outputs.
REQ-010 SHALL have port cnt  output  CW  meaning current counter value.
REQ-011 SHALL have port period_start  output  1  meaning one-clock pulse asserted while cnt==0 at the start of each period.
REQ-012 SHALL have port upd_pending  output  1  meaning pending values are captured but not yet applied.

Function
REQ-013 SHALL keep active registers P_act and D_act[i], plus pending registers P_pen and D_pen[i].
REQ-014 SHALL capture period/duty into pending on a load edge, set upd_pending, and never change active values mid-period.
REQ-015 SHALL overwrite pending values when load repeats before application: last write wins.
REQ-016 SHALL define the boundary cycle as the cycle in which en=1 and the next cnt value is 0 (wrap).
REQ-017 SHALL copy pending to active and clear upd_pending on the boundary edge if upd_pending=1.
REQ-018 SHALL, when load coincides with the boundary edge, apply the old pending values and capture the new ones as pending, leaving upd_pending=1.
REQ-019 SHALL, while en=0, apply pending to active on the next edge and hold cnt at 0.
REQ-020 SHALL, in sawtooth mode, count cnt 0,1,...,P_act then wrap to 0.
REQ-021 SHALL, with P_act=0, hold cnt at 0 so that every enabled cycle is a boundary.
REQ-022 SHALL register pwm_out[i] as (cnt < D_act[i]), with one clock latency from cnt.
REQ-023 SHALL give duty 0 -> constantly low; duty > P_act -> constantly high; otherwise D_act high clocks per period.
REQ-024 SHALL make comparisons unsigned at CW bits with no overflow; cnt never exceeds P_act.
REQ-025 SHALL drive pwm_out low on the edge after en falls; on en rise, counting starts at cnt=0 and period_start=1.
REQ-026 SHALL drive period_start combinationally from registered state as (en && cnt==0).

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force cnt=0, P_act=P_pen=2^CW-1, all D_act=D_pen=0, upd_pending=0, pwm_out=0, and count direction up.
REQ-028 SHALL, on rst_n deassertion mid-period, resume from cnt=0 with no pending update; loads issued before reset are lost.

Configuration
REQ-029 SHALL, with macro PWM_CENTER_ALIGN_EN defined, run cnt as an up/down triangle (0..P_act..1, e.g. P=3: 0,1,2,3,2,1,0...) with a period of 2*P_act clocks; the boundary per REQ-016 falls at the down-count cnt=1, or every cycle when P_act=0.
REQ-030 SHALL, with PWM_CENTER_ALIGN_EN defined, produce a pulse of 2*D_act clocks centred on cnt=0 for duty <= P_act.
REQ-031 SHALL, without PWM_CENTER_ALIGN_EN, implement sawtooth counting only, with no direction register.

Verification
REQ-032 SHALL pass this case: CH=4, CW=8, load P=99 and duties 20/40/60/80, en=1 -> period 100 clks, high counts 20/40/60/80, period_start every 100 clks.
REQ-033 SHALL pass this case: load duty0=50 at cnt=30 -> pwm_out[0] keeps the old width until the wrap, upd_pending=1 until then, new width from the next period.
REQ-034 SHALL pass this case: duty0=0, duty1=120 with P=99 -> pwm_out[0] never high, pwm_out[1] always high.
REQ-035 SHALL pass this case: load asserted on the boundary cycle with a pending update -> old pending applied, new values applied one period later.
REQ-036 SHALL pass this case: rst_n low at cnt=57 -> cnt=0 and pwm_out=0 immediately without a clock, and after release counting restarts at 0 with P=255.
REQ-037 SHALL pass this case: with PWM_CENTER_ALIGN_EN, P=10, duty=4 -> period 20 clks, pwm_out high 8 clks centred on cnt=0.
